// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//
// Stream handshake: a byte moves on a rising clock edge exactly when in_valid
// and in_ready are both high. The source holds in_data stable while in_valid is
// high and not yet accepted. in_ready depends only on loader state, never on
// in_valid. mem_we is a one-cycle write strobe that qualifies mem_addr and
// mem_wdata.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    // Byte source and memory side.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a framed little-endian byte stream (16-bit word count,
// 4*N data bytes, XOR checksum byte), writes the assembled 32-bit words
// sequentially into instruction memory and holds the core in reset until a
// frame has loaded with a matching checksum.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_rst,
    output logic          done,
    output logic          err,
    output logic [15:0]   loaded_words,
    output logic [2:0]    dbg_state
);

    // Largest legal word count; a frame may fill the memory exactly.
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        CNT_LO = 3'd0,
        CNT_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [15:0]           count;
    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic [7:0]            csum;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [15:0]           loaded_q;

    logic                  in_ready;
    logic                  accept;
    logic [15:0]           full_count;
    logic                  last_word;

    // Bytes are taken in every frame-parsing state, refused once a verdict is out.
    assign in_ready   = (state == CNT_LO) || (state == CNT_HI) ||
                        (state == DATA)   || (state == CSUM);
    assign accept     = bus.in_valid && in_ready;
    // Count as it will be once the high byte currently on the bus lands.
    assign full_count = {bus.in_data, count[7:0]};
    // loaded_q already counts every word completed before the one in flight.
    assign last_word  = (loaded_q + 16'd1) == count;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= CNT_LO;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: frame parsing, verdict, and restart from a verdict.
    always_comb begin
        state_next = state;
        case (state)
            CNT_LO: begin
                if (accept) state_next = CNT_HI;
            end
            CNT_HI: begin
                if (accept) begin
                    if ({1'b0, full_count} > DEPTH) begin
                        state_next = ERR;
                    end else if (full_count == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && (byte_idx == 2'd3) && last_word) state_next = CSUM;
            end
            CSUM: begin
                if (accept) state_next = (bus.in_data == csum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (start) state_next = CNT_LO;
            end
            default: state_next = CNT_LO;
        endcase
    end

    // Datapath: count capture, word assembly, checksum, registered write strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count       <= 16'd0;
            byte_idx    <= 2'd0;
            word_buf    <= 24'd0;
            csum        <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            loaded_q    <= 16'd0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                CNT_LO: begin
                    if (accept) count[7:0] <= bus.in_data;
                end
                CNT_HI: begin
                    if (accept) count[15:8] <= bus.in_data;
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.in_data;
                            2'd1: word_buf[15:8]  <= bus.in_data;
                            2'd2: word_buf[23:16] <= bus.in_data;
                            default: begin
                                // Fourth byte completes the word: write it next cycle.
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= loaded_q[ADDR_WIDTH-1:0];
                                mem_wdata_q <= {bus.in_data, word_buf};
                                loaded_q    <= loaded_q + 16'd1;
                            end
                        endcase
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        loaded_q <= 16'd0;
                        csum     <= 8'd0;
                        byte_idx <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign loaded_words  = loaded_q;
    assign done          = (state == DONE);
    assign err           = (state == ERR);
    assign core_rst      = (state != DONE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames from the test plan plus random frames,
// with memory writes and final status compared against a frame-level model.
module tb_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int W     = AW + 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [15:0] loaded_words;
    logic [2:0]  dbg_state;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .bus          (bus),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .loaded_words (loaded_words),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    int          tests  = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]  frame_q[$];
    int          exp_words;
    logic        exp_done;
    logic        exp_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected (addr, data).
    always @(negedge CLK) begin
        if (bus.mem_we === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_write got addr=%0d data=%h want no write",
                       bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                assert ({bus.mem_addr, bus.mem_wdata} === e) else begin
                    errors++;
                    $error("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                           bus.mem_addr, bus.mem_wdata, e[W-1:32], e[31:0]);
                end
            end
        end
    end

    // Reference model: expected writes and verdict straight from the frame rules.
    task automatic model_frame();
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        x = 8'h00;
        n = int'({frame_q[1], frame_q[0]});
        if (n > DEPTH) begin
            exp_done  = 1'b0;
            exp_err   = 1'b1;
            exp_words = 0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                w = w | (32'(frame_q[2 + 4 * k + j]) << (8 * j));
                x = x ^ frame_q[2 + 4 * k + j];
            end
            exp_q.push_back({AW'(k), w});
        end
        exp_words = n;
        exp_done  = (frame_q[2 + 4 * n] == x);
        exp_err   = !exp_done;
    endtask

    // Random frame of n words; checksum correct or deliberately corrupted.
    task automatic build_frame(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n > DEPTH) return;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x = x ^ b;
        end
        frame_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    // Driver: one byte, optional idle cycles first, bounded wait for in_ready.
    task automatic send_byte(input logic [7:0] b, input bit throttle);
        int guard;
        if (throttle) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        if (guard >= 20) begin
            tests++;
            errors++;
            $error("FAIL accept_timeout got in_ready=%b want 1", bus.in_ready);
        end else begin
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic send_frame(input bit throttle, input bit start_glitch);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], throttle);
            if (start_glitch && i == 4) pulse_start();
        end
    endtask

    task automatic check_final(input string tag);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_core_rst"}, 64'(core_rst), 64'(!exp_done));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_loaded_words"}, 64'(loaded_words), 64'(exp_words));
    endtask

    task automatic restart(input string tag);
        pulse_start();
        check({tag, "_rs_done"}, 64'(done), 64'd0);
        check({tag, "_rs_err"}, 64'(err), 64'd0);
        check({tag, "_rs_core_rst"}, 64'(core_rst), 64'd1);
        check({tag, "_rs_loaded"}, 64'(loaded_words), 64'd0);
        check({tag, "_rs_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values while RST is held
        #12;
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_loaded", 64'(loaded_words), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Nominal load with expectations written out by hand
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                    8'h33, 8'h03, 8'h03, 8'h00, 8'h31};
        exp_q     = '{{6'd0, 32'h00100113}, {6'd1, 32'h00030333}};
        exp_done  = 1'b1;
        exp_err   = 1'b0;
        exp_words = 2;
        send_frame(1'b0, 1'b0);
        check_final("nominal");

        // Bytes offered while DONE must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 1'b0;
        check("done_hold_done", 64'(done), 64'd1);
        check("done_hold_loaded", 64'(loaded_words), 64'd2);
        restart("nominal");

        // Bad checksum, then resend the good frame
        frame_q[10] = 8'h30;
        model_frame();
        send_frame(1'b0, 1'b0);
        check_final("bad_csum");
        restart("bad_csum");
        frame_q[10] = 8'h31;
        model_frame();
        send_frame(1'b0, 1'b0);
        check_final("resend");
        restart("resend");

        // Oversize count
        frame_q = '{8'h41, 8'h00};
        model_frame();
        send_frame(1'b0, 1'b0);
        check_final("oversize");
        restart("oversize");

        // Empty frames
        frame_q = '{8'h00, 8'h00, 8'h00};
        model_frame();
        send_frame(1'b0, 1'b0);
        check_final("empty_ok");
        restart("empty_ok");
        frame_q = '{8'h00, 8'h00, 8'h05};
        model_frame();
        send_frame(1'b0, 1'b0);
        check_final("empty_bad");
        restart("empty_bad");

        // Throttled nominal with an ignored start pulse mid-frame
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00,
                    8'h33, 8'h03, 8'h03, 8'h00, 8'h31};
        model_frame();
        send_frame(1'b1, 1'b1);
        check_final("throttled");
        restart("throttled");

        // Reset after 6 bytes: only word 0 is written
        exp_q = '{{6'd0, 32'h00100113}};
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1'b0);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #2;
        check("midrst_core_rst", 64'(core_rst), 64'd1);
        check("midrst_state", 64'(dbg_state), 64'd0);
        check("midrst_loaded", 64'(loaded_words), 64'd0);
        check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
        check("midrst_writes_left", 64'(exp_q.size()), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        model_frame();
        send_frame(1'b0, 1'b0);
        check_final("after_rst");
        restart("after_rst");

        // Count exactly filling the memory
        build_frame(DEPTH, 1'b1);
        model_frame();
        send_frame(1'b0, 1'b0);
        check_final("full_depth");
        restart("full_depth");

        // Random frames
        for (int t = 0; t < 12; t++) begin
            int n;
            case ($urandom_range(0, 7))
                0:       n = 0;
                1:       n = DEPTH + 1;
                default: n = $urandom_range(1, 8);
            endcase
            build_frame(n, 1'($urandom_range(0, 1)));
            model_frame();
            send_frame(1'($urandom_range(0, 1)), 1'b0);
            check_final("random");
            restart("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware program loader that writes the instruction memory over a byte stream; it replaces the `$readmemh` preload used in simulation.
- Accepts a framed little-endian byte stream, assembles 32-bit instruction words, writes them sequentially into the instruction ROM write port, and validates an XOR checksum.
- Holds the single-cycle core in reset until a frame has loaded correctly.
- Sits between an external byte source (UART receiver or debug port) and the `top` instruction memory and core reset.

Parameters:
- ADDR_WIDTH, 6, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts loading from DONE or ERR, ignored in other states.
- in_valid  input  1  byte source has data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address to write.
- mem_wdata  output  32  instruction word to write.
- core_rst  output  1  active-high reset to the core; released only on successful load.
- done  output  1  frame loaded and checksum matched.
- err  output  1  frame rejected.
- loaded_words  output  16  count of words written in the current frame.

Behaviour:
- Handshake: a byte is accepted on a rising edge when in_valid && in_ready. in_ready is combinational from state: 1 in CNT_LO, CNT_HI, DATA, CSUM; 0 in DONE and ERR.
- Frame format:
  - count N, 16-bit little-endian (lo byte first);
  - 4*N data bytes, each word little-endian (byte0 = bits 7:0);
  - 1 checksum byte = XOR of all 4*N data bytes. Count bytes are excluded; initial value 0x00.
- Reset (async) values: state CNT_LO, core_rst=1, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, loaded_words=0. Internal byte index=0, checksum accumulator=0.
- States:
  - CNT_LO: accept byte -> count[7:0]; go to CNT_HI.
  - CNT_HI: accept byte -> count[15:8].
    - Full count > DEPTH: go to ERR.
    - Full count == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: each accepted byte is shifted into the word buffer at byte position 0..3 and XORed into the accumulator.
    - On the 4th byte: the next cycle mem_we=1 with mem_addr=loaded_words[ADDR_WIDTH-1:0] and mem_wdata=assembled word, all registered; loaded_words increments in that same cycle.
    - After word N's 4th byte: go to CSUM. in_ready stays 1 throughout, with no bubble.
  - CSUM: accept byte.
    - Equal to accumulator: go to DONE; core_rst=0 and done=1 from the next cycle.
    - Otherwise: go to ERR; err=1, core_rst stays 1.
  - DONE / ERR: hold outputs. On start: go to CNT_LO; done=0, err=0, core_rst=1, loaded_words=0, accumulator=0, byte index=0 next cycle.
- mem_we is high for exactly one cycle per word, never in any other state. The final word's write may coincide with the first CSUM cycle.
- Memory contents beyond N are untouched; the loader never clears memory.
- start during CNT_LO..CSUM is ignored. in_valid in DONE/ERR is ignored, since in_ready=0.
- RST mid-frame: immediate return to reset values; a partially assembled word is discarded and not written.
- count == DEPTH is legal; addresses 0..DEPTH-1 are written with no wrap. count == DEPTH+1 goes to ERR.
- in_data is sampled only on handshake. Idle cycles (in_valid=0) anywhere in the frame do not change state.

Test Plan:
- Nominal load: bytes 02 00 13 01 10 00 33 03 03 00 31, in_valid held high -> mem_we pulses at addr 0 (data 0x00100113) and addr 1 (data 0x00030333). Then done=1, core_rst=0, err=0, loaded_words=2.
- Bad checksum: same frame with a final byte of 0x30 -> both words written, then err=1, done=0, core_rst=1. Next, a start pulse plus a resent correct frame -> done=1.
- Oversize count with ADDR_WIDTH=6: bytes 41 00 -> ERR right after the second byte, no mem_we ever, in_ready=0.
- Empty frame: bytes 00 00 00 -> done=1, loaded_words=0, no mem_we. Bytes 00 00 05 -> err=1.
- Throttled source: nominal frame with in_valid low on random cycles, including within a word and before the checksum -> identical writes and final status as the nominal load.
- Reset mid-frame: assert RST after 6 bytes of the nominal frame -> exactly one write (addr 0) before reset, core_rst=1, state CNT_LO. A full frame afterwards loads correctly.
